uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N byte-wide requesters using per-byte round-robin arbitration with optional lock
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req[N]            requester i has a byte pending (level)
//   data[8N]          flattened bytes, requester i at data[8i+7:8i]
//   lock[N]           requester i asks to keep the grant for its next byte
//   ack[N]            one-cycle pulse: byte from requester i accepted
//   grant[N]          one-hot owner of the transmitter
//   busy              arbiter is not idle
//   tx_data, tx_req   byte and one-cycle start pulse to the transmitter
//   tx_ready          transmitter idle/ready
module uart_tx_arbiter #(
   parameter int N         = 4,
   parameter int BUSY_WAIT = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [8*N-1:0] data,
   input  logic [N-1:0]   lock,
   output logic [N-1:0]   ack,
   output logic [N-1:0]   grant,
   output logic           busy,
   output logic [7:0]     tx_data,
   output logic           tx_req,
   input  logic           tx_ready
);
   localparam int LW = $clog2(N);
   localparam int CW = $clog2(BUSY_WAIT + 1);
   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
   state_t        state_q, state_d;
   logic [LW-1:0] last_q, last_d, win, sel;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  ack_q, ack_d, grant_q, grant_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_req_q, tx_req_d;
   logic          issue_new, done, reissue, rel, iss;
   // Scan from the lowest priority (last itself) to the highest so the
   // first requester after last is the one left standing.
   always_comb begin
      win = last_q;
      for (int i = N; i >= 1; i--)
         if (req[(int'(last_q) + i) % N]) win = LW'((int'(last_q) + i) % N);
   end
   assign issue_new = state_q == IDLE && tx_ready && |req;
   // Byte complete: transmitter back to ready, or it never went busy in time.
   assign done      = tx_ready && (state_q == WAIT_DONE ||
                      (state_q == WAIT_BUSY && cnt_q == CW'(BUSY_WAIT - 1)));
   // last_q always holds the current owner while granted.
   assign reissue   = done && lock[last_q] && req[last_q];
   assign rel       = done && !reissue;
   assign iss       = issue_new || reissue;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_q    <= LW'(N - 1);
         cnt_q     <= '0;
         ack_q     <= '0;
         grant_q   <= '0;
         tx_data_q <= '0;
         tx_req_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         grant_q   <= grant_d;
         tx_data_q <= tx_data_d;
         tx_req_q  <= tx_req_d;
      end
   end
   always_comb begin
      state_d = iss ? WAIT_BUSY :
                rel ? IDLE :
                (state_q == WAIT_BUSY && !tx_ready) ? WAIT_DONE : state_q;
      cnt_d   = iss ? '0 : state_q == WAIT_BUSY ? cnt_q + 1'b1 : cnt_q;
   end
   always_comb begin
      sel       = issue_new ? win : last_q;
      last_d    = issue_new ? win : last_q;
      tx_req_d  = iss;
      ack_d     = iss ? N'(1) << sel : '0;
      grant_d   = iss ? N'(1) << sel : rel ? '0 : grant_q;
      tx_data_d = iss ? data[int'(sel)*8 +: 8] : tx_data_q;
   end
   assign ack     = ack_q;
   assign grant   = grant_q;
   assign busy    = state_q != IDLE;
   assign tx_data = tx_data_q;
   assign tx_req  = tx_req_q;
endmodule
